// File: rtl/dma_channel_scheduler_if.sv
// Start/done handshake between the channel scheduler (master) and the single dma_engine (slave).
interface dma_channel_scheduler_if;
  logic [31:0] eng_src;
  logic [31:0] eng_dst;
  logic [31:0] eng_size;
  logic        eng_start;
  logic        eng_done;
  logic        eng_error;

  modport master (output eng_src, eng_dst, eng_size, eng_start, input eng_done, eng_error);
  modport slave  (input eng_src, eng_dst, eng_size, eng_start, output eng_done, eng_error);
endinterface

// File: rtl/dma_channel_scheduler.sv
// Round-robin front end that feeds per-channel DMA descriptors to one engine
// and keeps sticky per-channel done/error status.
module dma_ch_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        cmpl,
  input  logic        cmpl_err,
  input  logic        clr,
  input  logic [31:0] cfg_src,
  input  logic [31:0] cfg_dst,
  input  logic [31:0] cfg_size,
  output logic [31:0] src,
  output logic [31:0] dst,
  output logic [31:0] size,
  output logic        pending,
  output logic        done,
  output logic        error
);
  always_ff @(posedge clk) begin
    if (reset) begin
      src     <= '0;
      dst     <= '0;
      size    <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      if (load) begin
        src  <= cfg_src;
        dst  <= cfg_dst;
        size <= cfg_size;
      end
      // load and cmpl never coincide: loads need !pending, completions need pending
      pending <= load | (pending & ~cmpl);
      done    <= cmpl | (done & ~clr & ~load);
      error   <= (cmpl & cmpl_err) | (error & ~clr & ~load);
    end
  end
endmodule

module dma_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [31:0]          cfg_size,
  output logic                 cfg_reject,
  input  logic [NUM_CH-1:0]    clr_status,
  output logic [NUM_CH-1:0]    ch_pending,
  output logic [NUM_CH-1:0]    ch_done,
  output logic [NUM_CH-1:0]    ch_error,
  output logic                 active_valid,
  output logic [CH_W-1:0]      active_ch,
  output logic                 irq,
  dma_channel_scheduler_if.master eng
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]                    state;
  logic [CH_W-1:0]               rr_ptr;
  logic [NUM_CH-1:0][31:0]       slot_src, slot_dst, slot_size;
  logic [NUM_CH-1:0]             load, cmpl;
  logic                          cfg_ok, gnt_found, gnt_zero, issue_done, gnt_fire;
  logic [CH_W-1:0]               gnt_ch, cand;

  assign cfg_ok     = cfg_we && (int'(cfg_ch) < NUM_CH) && !ch_pending[cfg_ch];
  assign issue_done = (state == ISSUE) && eng.eng_done;
  assign gnt_fire   = (state == IDLE) && gnt_found;
  assign gnt_zero   = (slot_size[gnt_ch] == '0);
  assign irq        = |ch_done;

  // Search starts one past the last grant so every pending channel waits at most NUM_CH-1 turns.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (!gnt_found && ch_pending[cand]) begin
        gnt_found = 1'b1;
        gnt_ch    = cand;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = cfg_ok && (cfg_ch == CH_W'(i));
    assign cmpl[i] = (issue_done && (active_ch == CH_W'(i))) ||
                     (gnt_fire && gnt_zero && (gnt_ch == CH_W'(i)));
    dma_ch_slot u_slot (
      .clk      (clk),
      .reset    (reset),
      .load     (load[i]),
      .cmpl     (cmpl[i]),
      .cmpl_err (issue_done && eng.eng_error),
      .clr      (clr_status[i]),
      .cfg_src  (cfg_src),
      .cfg_dst  (cfg_dst),
      .cfg_size (cfg_size),
      .src      (slot_src[i]),
      .dst      (slot_dst[i]),
      .size     (slot_size[i]),
      .pending  (ch_pending[i]),
      .done     (ch_done[i]),
      .error    (ch_error[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= CH_W'(NUM_CH - 1);
      eng.eng_start <= 1'b0;
      eng.eng_src   <= '0;
      eng.eng_dst   <= '0;
      eng.eng_size  <= '0;
      active_valid  <= 1'b0;
      active_ch     <= '0;
      cfg_reject    <= 1'b0;
    end else begin
      cfg_reject <= cfg_we && !cfg_ok;
      case (state)
        IDLE: if (gnt_found) begin
          rr_ptr <= gnt_ch;
          if (!gnt_zero) begin
            eng.eng_src   <= slot_src[gnt_ch];
            eng.eng_dst   <= slot_dst[gnt_ch];
            eng.eng_size  <= slot_size[gnt_ch];
            eng.eng_start <= 1'b1;
            active_valid  <= 1'b1;
            active_ch     <= gnt_ch;
            state         <= ISSUE;
          end
        end
        ISSUE: if (eng.eng_done) begin
          eng.eng_start <= 1'b0;
          active_valid  <= 1'b0;
          state         <= RELEASE;
        end
        // Hold off until the engine drops done so it cannot re-latch a stale start.
        RELEASE: if (!eng.eng_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed plus randomized bench for dma_channel_scheduler against a descriptor-level model.
module tb_dma_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic clk;
  logic reset;
  logic cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [31:0] cfg_src, cfg_dst, cfg_size;
  logic cfg_reject;
  logic [NUM_CH-1:0] clr_status, ch_pending, ch_done, ch_error;
  logic active_valid;
  logic [CH_W-1:0] active_ch;
  logic irq;

  dma_channel_scheduler_if eng ();

  dma_channel_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_src(cfg_src),
    .cfg_dst(cfg_dst), .cfg_size(cfg_size), .cfg_reject(cfg_reject), .clr_status(clr_status),
    .ch_pending(ch_pending), .ch_done(ch_done), .ch_error(ch_error),
    .active_valid(active_valid), .active_ch(active_ch), .irq(irq), .eng(eng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: descriptor table, sticky flags, who owns the engine, and whether we wait for done to drop.
  bit          m_pend[NUM_CH], m_done[NUM_CH], m_err[NUM_CH];
  logic [31:0] m_src[NUM_CH], m_dst[NUM_CH], m_size[NUM_CH];
  int          m_rr, m_owner;
  bit          m_drain, m_rej;
  logic [31:0] m_es, m_ed, m_ez;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int gc, cc;
    bit ld, ce;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_pend[c] = 0; m_done[c] = 0; m_err[c] = 0;
        m_src[c] = 0; m_dst[c] = 0; m_size[c] = 0;
      end
      m_rr = NUM_CH - 1; m_owner = -1; m_drain = 0; m_rej = 0;
      m_es = 0; m_ed = 0; m_ez = 0;
      return;
    end
    cc = -1; ce = 0;
    if (m_owner >= 0) begin
      if (eng.eng_done) begin
        cc = m_owner; ce = eng.eng_error; m_owner = -1; m_drain = 1;
      end
    end else if (m_drain) begin
      if (!eng.eng_done) m_drain = 0;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        gc = (m_rr + k) % NUM_CH;
        if (m_pend[gc]) begin
          m_rr = gc;
          if (m_size[gc] == 0) cc = gc;
          else begin
            m_owner = gc; m_es = m_src[gc]; m_ed = m_dst[gc]; m_ez = m_size[gc];
          end
          break;
        end
      end
    end
    ld    = cfg_we && !m_pend[cfg_ch];
    m_rej = cfg_we && !ld;
    for (int c = 0; c < NUM_CH; c++)
      if (clr_status[c] || (ld && int'(cfg_ch) == c)) begin m_done[c] = 0; m_err[c] = 0; end
    if (ld) begin
      m_pend[cfg_ch] = 1; m_src[cfg_ch] = cfg_src; m_dst[cfg_ch] = cfg_dst; m_size[cfg_ch] = cfg_size;
    end
    if (cc >= 0) begin
      m_pend[cc] = 0; m_done[cc] = 1;
      if (ce) m_err[cc] = 1;
    end
  endtask

  task automatic compare();
    logic [NUM_CH-1:0] ep, ed, ee;
    for (int c = 0; c < NUM_CH; c++) begin ep[c] = m_pend[c]; ed[c] = m_done[c]; ee[c] = m_err[c]; end
    chk("pending", ch_pending, ep);
    chk("done", ch_done, ed);
    chk("error", ch_error, ee);
    chk("irq", irq, |ed);
    chk("reject", cfg_reject, m_rej);
    chk("start", eng.eng_start, m_owner >= 0);
    chk("active_valid", active_valid, m_owner >= 0);
    chk("eng_src", eng.eng_src, m_es);
    chk("eng_dst", eng.eng_dst, m_ed);
    chk("eng_size", eng.eng_size, m_ez);
    if (m_owner >= 0) chk("active_ch", active_ch, m_owner);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic wr(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] z);
    cfg_we = 1; cfg_ch = ch[CH_W-1:0]; cfg_src = s; cfg_dst = d; cfg_size = z;
    tick();
    cfg_we = 0;
  endtask

  task automatic wait_start(input int exp_ch);
    int n;
    n = 0;
    while (!eng.eng_start && n < 20) begin tick(); n++; end
    chk("start_seen", eng.eng_start, 1);
    chk("grant_ch", active_ch, exp_ch);
  endtask

  task automatic finish(input int lat, input bit err);
    repeat (lat) tick();
    eng.eng_done = 1; eng.eng_error = err;
    tick();
    eng.eng_done = 0; eng.eng_error = 0;
    tick();
  endtask

  initial begin
    int lat, hold;
    reset = 1; cfg_we = 0; cfg_ch = '0; cfg_src = 0; cfg_dst = 0; cfg_size = 0;
    clr_status = '0; eng.eng_done = 0; eng.eng_error = 0;
    tick(); tick();
    chk("rst_pending", ch_pending, 0); chk("rst_start", eng.eng_start, 0);
    chk("rst_irq", irq, 0); chk("rst_src", eng.eng_src, 0);
    reset = 0; tick();

    // single channel
    wr(1, 32'h1000, 32'h2000, 64);
    chk("sc_pend", ch_pending, 4'b0010); chk("sc_nostart", eng.eng_start, 0);
    tick();
    chk("sc_start", eng.eng_start, 1); chk("sc_src", eng.eng_src, 32'h1000);
    chk("sc_dst", eng.eng_dst, 32'h2000); chk("sc_size", eng.eng_size, 64);
    repeat (9) tick();
    eng.eng_done = 1; eng.eng_error = 0;
    tick();
    chk("sc_stop", eng.eng_start, 0); chk("sc_done", ch_done, 4'b0010);
    chk("sc_pend0", ch_pending, 0); chk("sc_irq", irq, 1);
    eng.eng_done = 0; tick();

    // round-robin, reload of ch0 waits behind ch3
    reset = 1; tick(); reset = 0;
    wr(0, 32'h100, 32'h200, 8); wr(2, 32'h300, 32'h400, 16); wr(3, 32'h500, 32'h600, 24);
    wait_start(0); finish(2, 0);
    wait_start(2); wr(0, 32'h5000, 32'h6000, 12); finish(3, 0);
    wait_start(3); finish(1, 0);
    wait_start(0); chk("rr_reload_src", eng.eng_src, 32'h5000); finish(1, 0);

    // error path and clear
    clr_status = '1; tick(); clr_status = '0;
    wr(2, 32'h7000, 32'h8000, 40);
    wait_start(2);
    repeat (2) tick();
    eng.eng_done = 1; eng.eng_error = 1; tick();
    chk("err_error", ch_error, 4'b0100); chk("err_done", ch_done, 4'b0100); chk("err_irq", irq, 1);
    eng.eng_done = 0; eng.eng_error = 0; clr_status = 4'b0100; tick(); clr_status = '0;
    chk("clr_done", ch_done, 0); chk("clr_error", ch_error, 0); chk("clr_irq", irq, 0);

    // reject write to active channel
    wr(1, 32'hA000, 32'hA100, 16);
    wait_start(1);
    wr(1, 32'hBBBB, 32'hCCCC, 99);
    chk("rej_pulse", cfg_reject, 1); chk("rej_src", eng.eng_src, 32'hA000);
    wr(0, 32'hC000, 32'hC100, 8);
    chk("rej_one_cycle", cfg_reject, 0); chk("rej_next_accept", ch_pending[0], 1);
    finish(1, 0);
    wait_start(0); finish(0, 0);

    // zero-size completion and done-hold handshake
    wr(3, 32'h0, 32'h0, 0);
    chk("zero_nostart0", eng.eng_start, 0);
    tick();
    chk("zero_done", ch_done[3], 1); chk("zero_pend", ch_pending[3], 0); chk("zero_nostart1", eng.eng_start, 0);
    wr(1, 32'hD000, 32'hD100, 32);
    wait_start(1);
    wr(0, 32'hE000, 32'hE100, 8);
    eng.eng_done = 1; tick();
    chk("hs_stop", eng.eng_start, 0);
    repeat (3) begin tick(); chk("hs_hold", eng.eng_start, 0); end
    eng.eng_done = 0; tick();
    chk("hs_idle", eng.eng_start, 0);
    tick();
    chk("hs_restart", eng.eng_start, 1); chk("hs_ch0", active_ch, 0);
    finish(0, 0);

    // reset mid-transfer
    clr_status = '1; tick(); clr_status = '0;
    wr(2, 32'hF000, 32'hF100, 4);
    wait_start(2);
    reset = 1; tick();
    chk("mr_start", eng.eng_start, 0); chk("mr_valid", active_valid, 0);
    chk("mr_done", ch_done, 0); chk("mr_pend", ch_pending, 0); chk("mr_src", eng.eng_src, 0);
    reset = 0; tick();

    // randomized traffic with a behavioural engine
    lat = 0; hold = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      reset = ($urandom_range(0, 499) == 0);
      if (reset) begin
        eng.eng_done = 0; eng.eng_error = 0;
      end else if (!eng.eng_done) begin
        if (eng.eng_start) begin
          if (lat == 0) begin
            eng.eng_done = 1; eng.eng_error = ($urandom_range(0, 3) == 0); hold = $urandom_range(0, 3);
          end else lat--;
        end else lat = $urandom_range(0, 5);
      end else if (!eng.eng_start) begin
        if (hold == 0) begin eng.eng_done = 0; eng.eng_error = 0; end
        else hold--;
      end
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_ch   = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_src  = $urandom;
      cfg_dst  = $urandom;
      cfg_size = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      clr_status = ($urandom_range(0, 7) == 0) ? NUM_CH'($urandom) : '0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
